// File: rtl/cfi_log_queue_pkg.sv
// Shared types for the CFI commit-log queue: privilege level, the log record
// and the kind-vector helper.
package riscv;
  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;
endpackage

package cfi_pkg;
  localparam int unsigned CFI_KIND_W = 4;

  typedef struct packed {
    logic [63:0]      pc;
    logic [63:0]      target;
    logic             is_return;
    logic             is_call;
    logic             is_jump;
    logic             is_branch;
    logic             taken;
    riscv::priv_lvl_t priv_lvl;
  } cfi_log_t;

  localparam cfi_log_t CFI_LOG_ZERO = cfi_log_t'({$bits(cfi_log_t){1'b0}});

  // Kind vector ordered {return, call, jump, branch} to line up with kind_en_i.
  function automatic logic [CFI_KIND_W-1:0] cfi_kind(input cfi_log_t log);
    return {log.is_return, log.is_call, log.is_jump, log.is_branch};
  endfunction
endpackage

// File: rtl/cfi_log_queue_compact.sv
// Combinational prefix-count compactor: assigns each qualified commit record a
// slot offset and keeps only as many as fit in the free space.
module cfi_log_compact #(
  parameter int unsigned NrPorts = 2,
  parameter int unsigned FreeW   = 4,
  parameter int unsigned OffW    = 1,
  parameter int unsigned NumW    = 2
) (
  input  logic [NrPorts-1:0]           valid_i,
  input  logic [NrPorts-1:0]           mask_i,
  input  logic [FreeW-1:0]             free_i,
  output logic [NrPorts-1:0][OffW-1:0] offset_o,
  output logic [NrPorts-1:0]           keep_o,
  output logic [NumW-1:0]              n_push_o,
  output logic [NumW-1:0]              n_drop_o
);
  int unsigned n_cand_s;
  int unsigned n_keep_s;

  // Running candidate count gives each record its slot; only the oldest `free` survive.
  always_comb begin
    n_cand_s = 32'd0;
    n_keep_s = 32'd0;
    offset_o = {(NrPorts*OffW){1'b0}};
    keep_o   = {NrPorts{1'b0}};
    for (int i = 0; i < NrPorts; i++) begin
      if (valid_i[i] && mask_i[i]) begin
        offset_o[i] = OffW'(n_cand_s);
        keep_o[i]   = (n_cand_s < 32'(free_i));
        n_cand_s    = n_cand_s + 32'd1;
      end else begin
        offset_o[i] = {OffW{1'b0}};
        keep_o[i]   = 1'b0;
      end
    end
    if (n_cand_s < 32'(free_i)) begin
      n_keep_s = n_cand_s;
    end else begin
      n_keep_s = 32'(free_i);
    end
    n_push_o = NumW'(n_keep_s);
    n_drop_o = NumW'(n_cand_s - n_keep_s);
  end
endmodule

// File: rtl/cfi_log_queue.sv
// Multi-port commit-to-CFI-checker log FIFO with kind filtering, in-order
// compaction, drop counting and a sticky overflow flag.
module cfi_log_queue
  import cfi_pkg::*;
#(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned Depth         = 8,
  parameter int unsigned CntWidth      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NrCommitPorts-1:0]             commit_valid_i,
  input  cfi_log_t [NrCommitPorts-1:0]         commit_log_i,
  input  logic [CFI_KIND_W-1:0]                kind_en_i,
  input  logic                                 clear_i,
  output logic                                 log_valid_o,
  input  logic                                 log_ready_i,
  output cfi_log_t                             log_o,
  output logic [$clog2(Depth+1)-1:0]           count_o,
  output logic [CntWidth-1:0]                  drop_cnt_o,
  output logic                                 overflow_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);
  localparam int unsigned NumW = $clog2(NrCommitPorts+1);
  localparam int unsigned OffW = (NrCommitPorts > 1) ? $clog2(NrCommitPorts) : 1;

  cfi_log_t                            mem_r [Depth];
  logic [PtrW-1:0]                     wr_ptr_r;
  logic [PtrW-1:0]                     rd_ptr_r;
  logic [CntW-1:0]                     count_r;
  logic [CntWidth-1:0]                 drop_cnt_r;
  logic                                overflow_r;

  logic [NrCommitPorts-1:0]            mask_s;
  logic [CntW-1:0]                     free_s;
  logic [NrCommitPorts-1:0][OffW-1:0]  offset_s;
  logic [NrCommitPorts-1:0]            keep_s;
  logic [NumW-1:0]                     n_push_s;
  logic [NumW-1:0]                     n_drop_s;
  logic                                pop_s;
  logic [CntWidth:0]                   drop_sum_s;
  logic [CntWidth-1:0]                 drop_next_s;

  // Per-port kind qualification and free space as seen at the start of the cycle.
  always_comb begin
    for (int i = 0; i < NrCommitPorts; i++) begin
      mask_s[i] = |(cfi_kind(commit_log_i[i]) & kind_en_i);
    end
    free_s = CntW'(Depth) - count_r;
    pop_s  = (count_r != {CntW{1'b0}}) && log_ready_i;
  end

  cfi_log_compact #(
    .NrPorts (NrCommitPorts),
    .FreeW   (CntW),
    .OffW    (OffW),
    .NumW    (NumW)
  ) u_compact (
    .valid_i  (commit_valid_i),
    .mask_i   (mask_s),
    .free_i   (free_s),
    .offset_o (offset_s),
    .keep_o   (keep_s),
    .n_push_o (n_push_s),
    .n_drop_o (n_drop_s)
  );

  // Saturating drop accumulation.
  always_comb begin
    drop_sum_s = (CntWidth+1)'(drop_cnt_r) + (CntWidth+1)'(n_drop_s);
    if (drop_sum_s[CntWidth]) begin
      drop_next_s = {CntWidth{1'b1}};
    end else begin
      drop_next_s = drop_sum_s[CntWidth-1:0];
    end
  end

  // Storage writes; contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NrCommitPorts; i++) begin
      if (!rst_i && keep_s[i]) begin
        mem_r[wr_ptr_r + PtrW'(offset_s[i])] <= commit_log_i[i];
      end
    end
  end

  // Pointers, occupancy and drop status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r   <= {PtrW{1'b0}};
      rd_ptr_r   <= {PtrW{1'b0}};
      count_r    <= {CntW{1'b0}};
      drop_cnt_r <= {CntWidth{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_r + PtrW'(n_push_s);
      rd_ptr_r <= rd_ptr_r + PtrW'(pop_s);
      count_r  <= count_r + CntW'(n_push_s) - CntW'(pop_s);
      if (clear_i) begin
        drop_cnt_r <= {CntWidth{1'b0}};
        overflow_r <= 1'b0;
      end else begin
        drop_cnt_r <= drop_next_s;
        overflow_r <= overflow_r | (n_drop_s != {NumW{1'b0}});
      end
    end
  end

  assign log_valid_o = (count_r != {CntW{1'b0}});
  assign log_o       = log_valid_o ? mem_r[rd_ptr_r] : CFI_LOG_ZERO;
  assign count_o     = count_r;
  assign drop_cnt_o  = drop_cnt_r;
  assign overflow_o  = overflow_r;
endmodule

// File: tb/tb_cfi_log_queue.sv
// Bench for cfi_log_queue: directed vector table followed by randomized
// traffic checked against a queue-based reference model.
module tb_cfi_log_queue;
  import cfi_pkg::*;

  localparam int N = 2;
  localparam int D = 8;
  localparam logic [3:0] BR = 4'b0001, JMP = 4'b0010, CALL = 4'b0100, RET = 4'b1000;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   cv;
  cfi_log_t [N-1:0] cl;
  logic [3:0]     en;
  logic           clr;
  logic           rdy;
  logic           lv, lv2;
  cfi_log_t       lo, lo2;
  logic [3:0]     cnt, cnt2;
  logic [15:0]    dc;
  logic [1:0]     dc2;
  logic           ov, ov2;

  always #5 clk = ~clk;

  cfi_log_queue #(.NrCommitPorts(N), .Depth(D), .CntWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .commit_valid_i(cv), .commit_log_i(cl),
    .kind_en_i(en), .clear_i(clr), .log_valid_o(lv), .log_ready_i(rdy),
    .log_o(lo), .count_o(cnt), .drop_cnt_o(dc), .overflow_o(ov));

  // Narrow-counter copy so saturation is reachable.
  cfi_log_queue #(.NrCommitPorts(N), .Depth(D), .CntWidth(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .commit_valid_i(cv), .commit_log_i(cl),
    .kind_en_i(en), .clear_i(clr), .log_valid_o(lv2), .log_ready_i(rdy),
    .log_o(lo2), .count_o(cnt2), .drop_cnt_o(dc2), .overflow_o(ov2));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  cfi_log_t mq[$];
  int       mdrop, mdrop2;
  bit       mov;

  function automatic cfi_log_t mklog(input logic [3:0] k, input logic [63:0] pc);
    cfi_log_t l;
    l = CFI_LOG_ZERO;
    l.pc        = pc;
    l.target    = pc + 64'h40;
    l.is_branch = k[0];
    l.is_jump   = k[1];
    l.is_call   = k[2];
    l.is_return = k[3];
    l.taken     = pc[2];
    l.priv_lvl  = pc[3] ? riscv::PRIV_LVL_M : riscv::PRIV_LVL_U;
    return l;
  endfunction

  task automatic model_step();
    int fr, nd, idx;
    if (rst) begin
      mq.delete(); mdrop = 0; mdrop2 = 0; mov = 0;
    end else begin
      fr = D - mq.size();
      nd = 0; idx = 0;
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      for (int i = 0; i < N; i++) begin
        if (cv[i] && ((cl[i].is_branch & en[0]) | (cl[i].is_jump & en[1]) |
                      (cl[i].is_call & en[2]) | (cl[i].is_return & en[3]))) begin
          if (idx < fr) mq.push_back(cl[i]);
          else nd++;
          idx++;
        end
      end
      mdrop  = (mdrop + nd > 65535) ? 65535 : mdrop + nd;
      mdrop2 = (mdrop2 + nd > 3) ? 3 : mdrop2 + nd;
      if (nd > 0) mov = 1;
      if (clr) begin mdrop = 0; mdrop2 = 0; mov = 0; end
    end
  endtask

  // Apply one cycle of inputs, advance model and clock, settle after the edge.
  task automatic drive(input logic [1:0] v, input logic [3:0] k0, input logic [63:0] pc0,
                       input logic [3:0] k1, input logic [63:0] pc1, input logic [3:0] e,
                       input logic r, input logic c, input logic rs);
    cv = v; cl[0] = mklog(k0, pc0); cl[1] = mklog(k1, pc1);
    en = e; rdy = r; clr = c; rst = rs;
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  k0, k1;
    logic [63:0] pc0, pc1;
    logic [3:0]  en;
    logic        rdy, clr, rs;
    int          cnt;
    logic [63:0] hpc;
    int          drop;
    logic        ov;
  } vec_t;

  function automatic vec_t mk(logic [1:0] v, logic [3:0] k0, logic [63:0] pc0,
                              logic [3:0] k1, logic [63:0] pc1, logic [3:0] e,
                              logic r, logic c, logic rs,
                              int xc, logic [63:0] xpc, int xd, logic xo);
    vec_t t;
    t.v = v; t.k0 = k0; t.pc0 = pc0; t.k1 = k1; t.pc1 = pc1; t.en = e;
    t.rdy = r; t.clr = c; t.rs = rs; t.cnt = xc; t.hpc = xpc; t.drop = xd; t.ov = xo;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    cv = '0; cl = '0; en = 4'hF; clr = 1'b0; rdy = 1'b0; rst = 1'b1;

    // Reset, single push/drain, dual-port order, filtering
    tbl.push_back(mk(2'b00, 4'h0, 64'h0, 4'h0, 64'h0, 4'hF, 0, 0, 1, 0, 64'h0, 0, 0));
    tbl.push_back(mk(2'b01, BR, 64'h8000_0000, 4'h0, 64'h0, 4'hF, 1, 0, 0, 1, 64'h8000_0000, 0, 0));
    tbl.push_back(mk(2'b00, 4'h0, 64'h0, 4'h0, 64'h0, 4'hF, 1, 0, 0, 0, 64'h0, 0, 0));
    tbl.push_back(mk(2'b11, CALL, 64'h100, RET, 64'h104, 4'hF, 0, 0, 0, 2, 64'h100, 0, 0));
    tbl.push_back(mk(2'b00, 4'h0, 64'h0, 4'h0, 64'h0, 4'hF, 1, 0, 0, 1, 64'h104, 0, 0));
    tbl.push_back(mk(2'b00, 4'h0, 64'h0, 4'h0, 64'h0, 4'hF, 1, 0, 0, 0, 64'h0, 0, 0));
    tbl.push_back(mk(2'b11, JMP, 64'h200, BR, 64'h204, 4'b0001, 0, 0, 0, 1, 64'h204, 0, 0));
    tbl.push_back(mk(2'b00, 4'h0, 64'h0, 4'h0, 64'h0, 4'hF, 1, 0, 0, 0, 64'h0, 0, 0));
    // Overflow: 10 records into 8 slots
    for (int c = 0; c < 5; c++)
      tbl.push_back(mk(2'b11, BR, 64'h1000 + 64'(8*c), BR, 64'h1004 + 64'(8*c), 4'hF, 0, 0, 0,
                       (2*(c+1) > 8) ? 8 : 2*(c+1), 64'h1000, (c == 4) ? 2 : 0, c == 4));
    tbl.push_back(mk(2'b00, 4'h0, 64'h0, 4'h0, 64'h0, 4'hF, 0, 1, 0, 8, 64'h1000, 0, 0));
    // Push while full with a pop: push still dropped
    tbl.push_back(mk(2'b01, BR, 64'h2000, 4'h0, 64'h0, 4'hF, 1, 0, 0, 7, 64'h1004, 1, 1));
    for (int j = 0; j < 7; j++)
      tbl.push_back(mk(2'b00, 4'h0, 64'h0, 4'h0, 64'h0, 4'hF, 1, 0, 0,
                       6 - j, (j == 6) ? 64'h0 : 64'h1008 + 64'(4*j), 1, 1));
    // Reset mid-stream with a push in the reset cycle
    tbl.push_back(mk(2'b11, BR, 64'h3000, CALL, 64'h3004, 4'hF, 0, 0, 0, 2, 64'h3000, 1, 1));
    tbl.push_back(mk(2'b11, JMP, 64'h3008, RET, 64'h300C, 4'hF, 0, 0, 0, 4, 64'h3000, 1, 1));
    tbl.push_back(mk(2'b01, BR, 64'h3010, 4'h0, 64'h0, 4'hF, 0, 0, 0, 5, 64'h3000, 1, 1));
    tbl.push_back(mk(2'b11, BR, 64'h3100, BR, 64'h3104, 4'hF, 0, 0, 1, 0, 64'h0, 0, 0));
    tbl.push_back(mk(2'b00, 4'h0, 64'h0, 4'h0, 64'h0, 4'hF, 0, 0, 0, 0, 64'h0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].k0, tbl[i].pc0, tbl[i].k1, tbl[i].pc1, tbl[i].en,
            tbl[i].rdy, tbl[i].clr, tbl[i].rs);
      chk($sformatf("vec%0d count", i), 160'(cnt), 160'(tbl[i].cnt));
      chk($sformatf("vec%0d valid", i), 160'(lv), 160'(tbl[i].cnt != 0));
      chk($sformatf("vec%0d head_pc", i), 160'(lo.pc), 160'(tbl[i].hpc));
      chk($sformatf("vec%0d drop_cnt", i), 160'(dc), 160'(tbl[i].drop));
      chk($sformatf("vec%0d overflow", i), 160'(ov), 160'(tbl[i].ov));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic r;
      r = (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      drive(2'($urandom), 4'($urandom), {$urandom, $urandom}, 4'($urandom), {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, r,
            $urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0);
      chk("rnd count", 160'(cnt), 160'(mq.size()));
      chk("rnd valid", 160'(lv), 160'(mq.size() != 0));
      chk("rnd head", 160'(lo), (mq.size() != 0) ? 160'(mq[0]) : 160'(0));
      chk("rnd drop_cnt", 160'(dc), 160'(mdrop));
      chk("rnd overflow", 160'(ov), 160'(mov));
      chk("rnd drop_sat", 160'(dc2), 160'(mdrop2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
